// File: rtl/ecc_scrub_ctrl_pkg.sv
// rtl/ecc_scrub_ctrl_pkg.sv - shared types, widths and helpers for the ECC scrub controller
package ecc_scrub_ctrl_pkg;

    localparam int CNT_W  = 16;
    localparam int DATA_W = 32;
    localparam int PAR_W  = 7;
    localparam int CPAR_W = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        RD_REQ  = 3'd2,
        RD_DATA = 3'd3,
        CHECK   = 3'd4,
        WR_REQ  = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/ecc_scrub_timer.sv
// rtl/ecc_scrub_timer.sv - loadable down-counter pacing the gap between scrub reads
module ecc_scrub_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// rtl/ecc_scrub_ctrl.sv - background ECC scrubber; define ECC_SCRUB_WRITEBACK_EN to write back corrected single errors
module ecc_scrub_ctrl
    import ecc_scrub_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int INTERVAL = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [PAR_W-1:0]  mem_wparity,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [PAR_W-1:0]  mem_rparity,
    output logic [DATA_W-1:0] ecc_data,
    output logic [PAR_W-1:0]  ecc_parity,
    input  logic [DATA_W-1:0] ecc_corr_data,
    input  logic [CPAR_W-1:0] ecc_corr_parity,
    input  logic              ecc_single,
    input  logic              ecc_double,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count,
    output logic              ded_irq,
    output logic [ADDR_W-1:0] ded_addr,
    output logic              busy,
    output logic              pass_done
);

    localparam int TMR_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   ecc_data_q, ecc_data_d;
    logic [PAR_W-1:0]    ecc_par_q, ecc_par_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [PAR_W-1:0]    wpar_q, wpar_d;
    logic [CNT_W-1:0]    sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0]    ded_cnt_q, ded_cnt_d;
    logic                ded_irq_q, ded_irq_d;
    logic [ADDR_W-1:0]   ded_addr_q, ded_addr_d;
    logic                pass_done_q, pass_done_d;
    logic                tmr_load, tmr_dec, tmr_zero;
    logic                advance;

    ecc_scrub_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (TMR_W'(INTERVAL - 1)),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ecc_data_d  = ecc_data_q;
        ecc_par_d   = ecc_par_q;
        wdata_d     = wdata_q;
        wpar_d      = wpar_q;
        sec_cnt_d   = sec_cnt_q;
        ded_cnt_d   = ded_cnt_q;
        ded_irq_d   = 1'b0;
        ded_addr_d  = ded_addr_q;
        pass_done_d = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        advance     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = WAIT;
                    tmr_load = 1'b1;
                end
            end
            WAIT: begin
                if (tmr_zero) begin
                    state_d = RD_REQ;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            RD_REQ: begin
                if (mem_gnt) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (mem_rvalid) begin
                    ecc_data_d = mem_rdata;
                    ecc_par_d  = mem_rparity;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                // Latch the write-back word so it cannot move while a write waits for grant.
                wdata_d = ecc_corr_data;
                wpar_d  = {^{ecc_corr_data, ecc_corr_parity}, ecc_corr_parity};
                if (ecc_double) begin
                    ded_cnt_d  = sat_inc(ded_cnt_q);
                    ded_irq_d  = 1'b1;
                    ded_addr_d = addr_q;
                    advance    = 1'b1;
                end else if (ecc_single) begin
                    sec_cnt_d = sat_inc(sec_cnt_q);
`ifdef ECC_SCRUB_WRITEBACK_EN
                    state_d   = WR_REQ;
`else
                    advance   = 1'b1;
`endif
                end else begin
                    advance = 1'b1;
                end
            end
            WR_REQ: begin
                if (mem_gnt) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // enable is only honoured here, so an access in flight always completes.
        if (advance) begin
            addr_d      = addr_q + ADDR_W'(1);
            pass_done_d = &addr_q;
            state_d     = enable ? WAIT : IDLE;
            tmr_load    = enable;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            ecc_data_q  <= '0;
            ecc_par_q   <= '0;
            wdata_q     <= '0;
            wpar_q      <= '0;
            sec_cnt_q   <= '0;
            ded_cnt_q   <= '0;
            ded_irq_q   <= 1'b0;
            ded_addr_q  <= '0;
            pass_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ecc_data_q  <= ecc_data_d;
            ecc_par_q   <= ecc_par_d;
            wdata_q     <= wdata_d;
            wpar_q      <= wpar_d;
            sec_cnt_q   <= sec_cnt_d;
            ded_cnt_q   <= ded_cnt_d;
            ded_irq_q   <= ded_irq_d;
            ded_addr_q  <= ded_addr_d;
            pass_done_q <= pass_done_d;
        end
    end

    assign mem_req     = (state_q == RD_REQ) || (state_q == WR_REQ);
`ifdef ECC_SCRUB_WRITEBACK_EN
    assign mem_we      = (state_q == WR_REQ);
`else
    assign mem_we      = 1'b0;
`endif
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wparity = wpar_q;
    assign ecc_data    = ecc_data_q;
    assign ecc_parity  = ecc_par_q;
    assign sec_count   = sec_cnt_q;
    assign ded_count   = ded_cnt_q;
    assign ded_irq     = ded_irq_q;
    assign ded_addr    = ded_addr_q;
    assign busy        = (state_q != IDLE);
    assign pass_done   = pass_done_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb/tb_ecc_scrub_ctrl.sv - self-checking bench for ecc_scrub_ctrl (ADDR_W=2, INTERVAL=4)
module tb_ecc_scrub_ctrl;

    localparam int AW     = 2;
    localparam int NW     = 4;
    localparam int RD_LAT = 3;
    localparam logic [6:0]  PAR_OK  = 7'h0A;
    localparam logic [6:0]  PAR_SGL = 7'h55;
    localparam logic [6:0]  PAR_DBL = 7'h7F;
    localparam logic [31:0] FLIP    = 32'h0000_0100;
`ifdef ECC_SCRUB_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, enable;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr, ded_addr;
    logic [31:0]   mem_wdata, mem_rdata, ecc_data, ecc_corr_data;
    logic [6:0]    mem_wparity, mem_rparity, ecc_parity;
    logic [5:0]    ecc_corr_parity;
    logic          ecc_single, ecc_double, ded_irq, busy, pass_done;
    logic [15:0]   sec_count, ded_count;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [6:0]    wpar;
    } acc_t;

    typedef struct {
        string name;
        int    kind;
        int    eaddr;
        int    exp_sec;
        int    exp_ded;
        int    exp_ded_addr;
        int    exp_coinc;
    } vec_t;

    acc_t          exp_q[$];
    logic [AW-1:0] exp_ded_q[$];
    vec_t          vecs[5];
    logic [31:0]   mem_d[NW];
    logic [6:0]    mem_p[NW];
    int            err_kind[NW];
    int            n_checks, n_fail;
    int            stall_left, rd_cnt, rd_gnt_cnt, pass_seen, coinc_seen;
    logic [AW-1:0] rd_addr;

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(.ADDR_W(AW), .INTERVAL(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wparity     (mem_wparity),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .mem_rparity     (mem_rparity),
        .ecc_data        (ecc_data),
        .ecc_parity      (ecc_parity),
        .ecc_corr_data   (ecc_corr_data),
        .ecc_corr_parity (ecc_corr_parity),
        .ecc_single      (ecc_single),
        .ecc_double      (ecc_double),
        .sec_count       (sec_count),
        .ded_count       (ded_count),
        .ded_irq         (ded_irq),
        .ded_addr        (ded_addr),
        .busy            (busy),
        .pass_done       (pass_done)
    );

    // Stand-in SEC-DED decoder: parity tags mark single (bit 8 flipped) or double errors.
    assign ecc_double      = (ecc_parity == PAR_DBL);
    assign ecc_single      = (ecc_parity == PAR_SGL) || (ecc_parity == PAR_DBL);
    assign ecc_corr_data   = (ecc_parity == PAR_SGL) ? (ecc_data ^ FLIP) : ecc_data;
    assign ecc_corr_parity = ecc_parity[5:0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] wb_par(input logic [31:0] d, input logic [5:0] p6);
        return {^{d, p6}, p6};
    endfunction

    task automatic load_mem(input int seed);
        for (int a = 0; a < NW; a++) begin
            mem_d[a] = 32'h3C5A_0000 ^ (seed << 12) ^ (a * 32'h0101_0111);
            mem_p[a] = (err_kind[a] == 1) ? PAR_SGL : (err_kind[a] == 2) ? PAR_DBL : PAR_OK;
        end
    endtask

    task automatic push_pass();
        acc_t e;
        for (int a = 0; a < NW; a++) begin
            e = '{we: 1'b0, addr: AW'(a), wdata: 32'h0, wpar: 7'h0};
            exp_q.push_back(e);
            if (WB && err_kind[a] == 1) begin
                e.we    = 1'b1;
                e.wdata = mem_d[a] ^ FLIP;
                e.wpar  = wb_par(mem_d[a] ^ FLIP, PAR_SGL[5:0]);
                exp_q.push_back(e);
            end
            if (err_kind[a] == 2) exp_ded_q.push_back(AW'(a));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        stall_left = 0;
        exp_q.delete();
        exp_ded_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_pass(input string tag);
        int t;
        enable = 1'b1;
        t = 0;
        while (!(mem_req && !mem_we && mem_addr == 2'd3) && t < 500) begin
            @(negedge clk);
            t++;
        end
        enable = 1'b0;
        t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_idle"}, 64'(busy), 64'(0));
        @(negedge clk);
        check({tag, "_acc_left"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_ded_left"}, 64'(exp_ded_q.size()), 64'(0));
    endtask

    // Memory responder and access scoreboard.
    initial begin
        acc_t e;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rparity = '0;
        rd_cnt = 0; rd_gnt_cnt = 0; rd_addr = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (reset) begin
                rd_cnt = 0;
            end else begin
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = mem_d[rd_addr];
                        mem_rparity = mem_p[rd_addr];
                    end
                end
                if (mem_req && stall_left > 0) begin
                    stall_left--;
                    if (exp_q.size() > 0)
                        check("stall_hold", {63'(0), mem_we, mem_addr}, {63'(0), exp_q[0].we, exp_q[0].addr});
                    check("stall_busy", 64'(busy), 64'(1));
                end else if (mem_req) begin
                    mem_gnt = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_access", {63'(0), mem_we, mem_addr}, 64'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("acc_we_addr", {63'(0), mem_we, mem_addr}, {63'(0), e.we, e.addr});
                        if (e.we) begin
                            check("wb_data", 64'(mem_wdata), 64'(e.wdata));
                            check("wb_parity", 64'(mem_wparity), 64'(e.wpar));
                        end
                    end
                    if (mem_we) begin
                        mem_d[mem_addr] = mem_wdata;
                        mem_p[mem_addr] = mem_wparity;
                    end else begin
                        rd_cnt = RD_LAT;
                        rd_addr = mem_addr;
                        rd_gnt_cnt++;
                    end
                end
            end
        end
    end

    // Interrupt / pass monitor.
    initial begin
        pass_seen = 0;
        coinc_seen = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ded_irq) begin
                    if (exp_ded_q.size() == 0) check("unexpected_ded", 64'(ded_addr), 64'hFFFF);
                    else check("ded_addr_at_irq", 64'(ded_addr), 64'(exp_ded_q.pop_front()));
                    if (pass_done) coinc_seen++;
                end
                if (pass_done) pass_seen++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, c0, g0, t;
        n_checks = 0;
        n_fail = 0;
        stall_left = 0;
        reset = 1'b1;
        enable = 1'b0;
        for (int a = 0; a < NW; a++) err_kind[a] = 0;

        vecs[0] = '{"clean",  0, 0, 0, 0, 0, 0};
        vecs[1] = '{"sgl_a2", 1, 2, 1, 0, 0, 0};
        vecs[2] = '{"dbl_a1", 2, 1, 0, 1, 1, 0};
        vecs[3] = '{"dbl_a3", 2, 3, 0, 1, 3, 1};
        vecs[4] = '{"sgl_a0", 1, 0, 1, 0, 0, 0};

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_req", {62'(0), mem_req, mem_we}, 64'(0));
        check("rst_counts", {32'(0), sec_count, ded_count}, 64'(0));
        check("rst_pulses", {61'(0), ded_irq, pass_done, 1'b0}, 64'(0));
        check("rst_ded_addr", 64'(ded_addr), 64'(0));

        for (int i = 0; i < 5; i++) begin
            do_reset();
            for (int a = 0; a < NW; a++) err_kind[a] = (a == vecs[i].eaddr) ? vecs[i].kind : 0;
            load_mem(i);
            push_pass();
            p0 = pass_seen;
            c0 = coinc_seen;
            run_pass(vecs[i].name);
            check({vecs[i].name, "_sec"}, 64'(sec_count), 64'(vecs[i].exp_sec));
            check({vecs[i].name, "_ded"}, 64'(ded_count), 64'(vecs[i].exp_ded));
            check({vecs[i].name, "_ded_addr"}, 64'(ded_addr), 64'(vecs[i].exp_ded_addr));
            check({vecs[i].name, "_passes"}, 64'(pass_seen - p0), 64'(1));
            check({vecs[i].name, "_coinc"}, 64'(coinc_seen - c0), 64'(vecs[i].exp_coinc));
        end

        // Grant withheld for ten cycles on the first read.
        do_reset();
        for (int a = 0; a < NW; a++) err_kind[a] = 0;
        load_mem(7);
        push_pass();
        p0 = pass_seen;
        stall_left = 10;
        run_pass("stall");
        check("stall_consumed", 64'(stall_left), 64'(0));
        check("stall_passes", 64'(pass_seen - p0), 64'(1));
        check("stall_sec", 64'(sec_count), 64'(0));

        // Counter saturation from a preloaded value.
        do_reset();
        force dut.sec_cnt_q = 16'hFFFD;
        @(negedge clk);
        release dut.sec_cnt_q;
        @(negedge clk);
        check("sat_preload", 64'(sec_count), 64'hFFFD);
        for (int a = 0; a < NW; a++) err_kind[a] = 1;
        load_mem(9);
        push_pass();
        run_pass("sat");
        check("sat_sec", 64'(sec_count), 64'hFFFF);
        check("sat_ded", 64'(ded_count), 64'(0));

        // Reset while a read is outstanding.
        for (int a = 0; a < NW; a++) err_kind[a] = 0;
        load_mem(11);
        exp_q.push_back('{we: 1'b0, addr: 2'd0, wdata: 32'h0, wpar: 7'h0});
        g0 = rd_gnt_cnt;
        enable = 1'b1;
        t = 0;
        while (rd_gnt_cnt == g0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("rd_granted", 64'(rd_gnt_cnt - g0), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_req", {62'(0), mem_req, mem_we}, 64'(0));
        check("mid_rst_counts", {32'(0), sec_count, ded_count}, 64'(0));
        check("mid_rst_pulses", {62'(0), ded_irq, pass_done}, 64'(0));
        check("mid_rst_ecc", {25'(0), ecc_data, ecc_parity}, 64'(0));
        check("mid_rst_ded_addr", 64'(ded_addr), 64'(0));
        check("mid_rst_acc_left", 64'(exp_q.size()), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        p0 = pass_seen;
        push_pass();
        run_pass("restart");
        check("restart_passes", 64'(pass_seen - p0), 64'(1));
        check("restart_sec", 64'(sec_count), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory word-address width.
REQ-002 SHALL have parameter INTERVAL, default 256, idle cycles between scrub reads (>=1).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  level; 1 = scrubbing runs, 0 = stop at next IDLE.
REQ-006 mem_req  out  1  memory access request; held until mem_gnt.
REQ-007 mem_we  out  1  1 = write-back, 0 = read; valid with mem_req.
REQ-008 mem_addr  out  ADDR_W  word address; valid with mem_req.
REQ-009 mem_wdata / mem_wparity  out  32 / 7  write-back data and parity.
REQ-010 mem_gnt  in  1  request accepted this cycle.
REQ-011 mem_rvalid / mem_rdata / mem_rparity  in  1 / 32 / 7  read return, arbitrary latency >=1 after gnt.
REQ-012 ecc_data / ecc_parity  out  32 / 7  registered read word driven to external combinational SEC-DED decoder.
REQ-013 ecc_corr_data / ecc_corr_parity / ecc_single / ecc_double  in  32 / 6 / 1 / 1  decoder results.
REQ-014 sec_count / ded_count  out  16 / 16  saturating error counters.
REQ-015 ded_irq  out  1  one-cycle pulse per double error; ded_addr out ADDR_W holds its address.
REQ-016 busy  out  1  FSM not in IDLE; pass_done out 1 one-cycle pulse when address wraps to 0.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RD_REQ, RD_DATA, CHECK, WR_REQ.
REQ-018 IDLE -> WAIT when enable=1; WAIT loads interval counter INTERVAL-1 and decrements to 0, then -> RD_REQ.
REQ-019 RD_REQ: mem_req=1, mem_we=0, mem_addr=addr; -> RD_DATA on mem_gnt.
REQ-020 RD_DATA: on mem_rvalid capture rdata/rparity into ecc_data/ecc_parity registers; -> CHECK.
REQ-021 CHECK (exactly one cycle): sample decoder; ecc_double -> ded_count+1, ded_irq=1, ded_addr=addr, -> advance; ecc_single&!ecc_double -> sec_count+1, -> WR_REQ (if write-back compiled in) else advance; none -> advance.
REQ-022 WR_REQ: mem_req=1, mem_we=1, mem_wdata=ecc_corr_data, mem_wparity={^{ecc_corr_data,ecc_corr_parity}, ecc_corr_parity}; -> advance on mem_gnt.
REQ-023 Advance: addr+1 modulo 2^ADDR_W; on wrap to 0 pulse pass_done; -> WAIT if enable else IDLE.
REQ-024 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-025 enable deassertion mid-access SHALL NOT abort an outstanding request; the access completes and the FSM then enters IDLE.
REQ-026 mem_req and mem_wdata/mem_addr SHALL stay stable while mem_req=1 and mem_gnt=0.
REQ-027 ded_irq and pass_done in the same cycle SHALL both assert.

Reset
REQ-028 On reset: state IDLE, addr 0, counters 0, mem_req 0, mem_we 0, ded_irq 0, pass_done 0, busy 0, ded_addr 0, ecc_data/ecc_parity 0; reset mid-transaction abandons it without write.

Configuration
REQ-029 Macro ECC_SCRUB_WRITEBACK_EN defined: single errors go through WR_REQ; undefined: WR_REQ unreachable, mem_we tied 0, single errors only counted.

Structure
REQ-030 Shared package SHALL hold the state enum typedef, counter width constant (16) and data/parity widths (32/7).
REQ-031 Interval counter SHALL be a sub-module ecc_scrub_timer (load, decrement, zero flag).

Verification
REQ-032 Clean memory, INTERVAL=4, ADDR_W=2 -> four reads, addresses 0..3, pass_done pulse after addr 3, counters 0.
REQ-033 Single error at addr 2 (WRITEBACK_EN) -> sec_count=1, one write to addr 2 with corrected data and recomputed parity[6].
REQ-034 Double error at addr 1 -> ded_irq one cycle, ded_addr=1, ded_count=1, no write.
REQ-035 mem_gnt held low 10 cycles during RD_REQ -> mem_req/mem_addr stable, no state advance.
REQ-036 sec_count preloaded via 65537 forced singles -> holds 16'hFFFF.
REQ-037 reset asserted during RD_DATA -> all outputs at reset values next cycle, scrub restarts at addr 0.
